// File: rtl/zeroriscy_dual_port_mem.sv
// zeroriscy_dual_port_mem
// Dual-port word memory slave for the zeroriscy instruction and data
// req/gnt/rvalid interfaces. The instruction port is read-only; the data port
// supports byte-enabled writes. Both ports accept one request per cycle and
// return responses in order exactly LAT cycles after the grant.
// Accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) return err = 1, rdata = 0,
// and never modify memory.
// Optional build macro MEM_STALL_EN: per-port 16-bit LFSR throttles the grants
// (about 25% stall cycles, repeatable from reset). Without it, grant follows
// request combinationally.
// LAT must lie in 1..8; DEPTH may be any value up to 2**30.

module zeroriscy_dual_port_mem #(
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LAT        = 2,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage; deliberately not reset so contents survive rst_i.
  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Grant generation
  // ---------------------------------------------------------------------------
`ifdef MEM_STALL_EN
  logic [15:0] instr_lfsr;
  logic [15:0] data_lfsr;

  // Fibonacci LFSRs (taps 16,14,13,11); seeds differ per port so the two
  // stall patterns are not identical.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_lfsr <= STALL_SEED;
      data_lfsr  <= STALL_SEED ^ 16'hFFFF;
    end else begin
      instr_lfsr <= {instr_lfsr[14:0],
                     instr_lfsr[15] ^ instr_lfsr[13] ^ instr_lfsr[12] ^ instr_lfsr[10]};
      data_lfsr  <= {data_lfsr[14:0],
                     data_lfsr[15] ^ data_lfsr[13] ^ data_lfsr[12] ^ data_lfsr[10]};
    end
  end

  assign instr_gnt_o = instr_req_i & ~rst_i & (instr_lfsr[1:0] != 2'b00);
  assign data_gnt_o  = data_req_i  & ~rst_i & (data_lfsr[1:0]  != 2'b00);
`else
  assign instr_gnt_o = instr_req_i & ~rst_i;
  assign data_gnt_o  = data_req_i  & ~rst_i;
`endif

  logic instr_acc;
  logic data_acc;

  assign instr_acc = instr_req_i & instr_gnt_o;
  assign data_acc  = data_req_i  & data_gnt_o;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]   instr_off;
  logic [31:0]   instr_word;
  logic          instr_hit;
  logic [AW-1:0] instr_idx;
  logic [31:0]   instr_rd;

  logic [31:0]   data_off;
  logic [31:0]   data_word;
  logic          data_hit;
  logic [AW-1:0] data_idx;
  logic [31:0]   data_rd;

  // Window check and word index for both ports; byte offset bits are ignored.
  always_comb begin
    instr_off  = instr_addr_i - BASE_ADDR;
    instr_word = instr_off >> 2;
    instr_hit  = (instr_addr_i >= BASE_ADDR) && (instr_word < DEPTH);
    instr_idx  = instr_word[AW-1:0];

    data_off   = data_addr_i - BASE_ADDR;
    data_word  = data_off >> 2;
    data_hit   = (data_addr_i >= BASE_ADDR) && (data_word < DEPTH);
    data_idx   = data_word[AW-1:0];
  end

  // Read ports see the pre-edge array contents, which gives read-before-write
  // for an instruction read colliding with a same-cycle data write.
  always_comb begin
    instr_rd = '0;
    data_rd  = '0;
    if (instr_hit) begin
      instr_rd = mem[instr_idx];
    end
    if (data_hit) begin
      data_rd = mem[data_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write
  // ---------------------------------------------------------------------------
  // Byte-lane write on an accepted in-window data write; be = 0 is a no-op.
  always_ff @(posedge clk_i) begin
    if (data_acc && data_we_i && data_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[data_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipelines: LAT stages of {valid, err, rdata} per port.
  // Stage 0 is loaded at the accept edge, so the final stage (LAT-1) is
  // visible LAT cycles after the grant. Idle slots carry all zeros so the
  // outputs read 0 whenever rvalid is low.
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] instr_pv;
  logic [LAT-1:0] instr_pe;
  logic [31:0]    instr_pd [LAT];

  logic [LAT-1:0] data_pv;
  logic [LAT-1:0] data_pe;
  logic [31:0]    data_pd [LAT];

  // Instruction response shift register; reset drops in-flight responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_pv <= '0;
      instr_pe <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        instr_pd[i] <= '0;
      end
    end else begin
      instr_pv[0] <= instr_acc;
      instr_pe[0] <= instr_acc & ~instr_hit;
      instr_pd[0] <= instr_acc ? instr_rd : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        instr_pv[i] <= instr_pv[i-1];
        instr_pe[i] <= instr_pe[i-1];
        instr_pd[i] <= instr_pd[i-1];
      end
    end
  end

  // Data response shift register; writes respond with rdata = 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_pv <= '0;
      data_pe <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        data_pd[i] <= '0;
      end
    end else begin
      data_pv[0] <= data_acc;
      data_pe[0] <= data_acc & ~data_hit;
      data_pd[0] <= (data_acc && !data_we_i) ? data_rd : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        data_pv[i] <= data_pv[i-1];
        data_pe[i] <= data_pe[i-1];
        data_pd[i] <= data_pd[i-1];
      end
    end
  end

  assign instr_rvalid_o = instr_pv[LAT-1];
  assign instr_err_o    = instr_pe[LAT-1];
  assign instr_rdata_o  = instr_pd[LAT-1];

  assign data_rvalid_o  = data_pv[LAT-1];
  assign data_err_o     = data_pe[LAT-1];
  assign data_rdata_o   = data_pd[LAT-1];

endmodule

// File: doc/zeroriscy_dual_port_mem.md
Name: zeroriscy_dual_port_mem

Overview:
- Parametrised, synthesisable dual-port memory slave that serves the zeroriscy core's instruction and data req/gnt/rvalid interfaces.
- Replaces the undriven memory hookups in the core-level testbench. Also usable as an on-chip scratch RAM.
- Instruction port is read-only; data port supports byte-enabled writes.
- Both ports are fully pipelined, with configurable response latency, address window and error signalling.

Parameters:
- DEPTH, 4096, number of 32-bit words (power of two not required).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned.
- LAT, 2, response latency in cycles from grant to rvalid; legal range 1..8.
- STALL_SEED, 16'hACE1, LFSR reset seed; used only with MEM_STALL_EN.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_req_i  in  1  instruction read request.
- instr_gnt_o  out  1  instruction request accepted this cycle.
- instr_addr_i  in  32  instruction byte address.
- instr_rvalid_o  out  1  instruction response valid.
- instr_rdata_o  out  32  instruction read data.
- instr_err_o  out  1  instruction response is an error (out of window).
- data_req_i  in  1  data request.
- data_gnt_o  out  1  data request accepted.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables; bit n selects bits 8n+7:8n.
- data_addr_i  in  32  data byte address.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  data response valid; asserted for reads and writes.
- data_rdata_o  out  32  data read data; 0 for writes.
- data_err_o  out  1  data response is an error.

Behaviour:
- Reset (rst_i = 1, sampled at the clock edge):
  - All rvalid, rdata, err outputs and response pipelines clear to 0.
  - gnt outputs are forced to 0 combinationally while rst_i is high.
  - Memory contents are not cleared; writes completed before reset persist.
  - In-flight responses at reset are dropped and never returned.
- Grant without MEM_STALL_EN: gnt_o = req_i & ~rst_i, combinational. One request can be accepted per cycle per port; the ports are independent.
- Accept: a request is accepted in any cycle where req and gnt are both 1. Address, we, be and wdata are sampled at that edge.
- Address decode:
  - off = addr - BASE_ADDR (32-bit unsigned); idx = off[31:2]; addr[1:0] is ignored.
  - In range when addr >= BASE_ADDR and idx < DEPTH.
- Out-of-range access: the write is suppressed, the response has err = 1 and rdata = 0, with the same latency as a normal access.
- Read: mem[idx] is read at the accept edge and delivered exactly LAT cycles later.
  - rvalid is high for exactly one cycle per accepted request.
  - Responses return in order; back-to-back accepts give back-to-back rvalids.
- Write: each byte lane with be = 1 updates mem[idx] at the accept edge; lanes with be = 0 are unchanged. be = 4'b0000 is a legal no-op write that still responses. Response: rvalid after LAT cycles, rdata = 0, err = 0.
- Same-cycle collision (instr read and data write to the same word): the instr read returns the old data (read-before-write).
- Data read at cycle t+1 after a write accepted at cycle t to the same word returns the new data.
- Response pipeline: a LAT-stage shift register per port holding {valid, err, rdata}. Outputs come from the final stage, are registered, and hold 0 when valid = 0.

Optional Feature:
- MEM_STALL_EN defined:
  - Each port has a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to STALL_SEED on instr and STALL_SEED^16'hFFFF on data. The LFSR advances every cycle when not in reset.
  - gnt_o = req_i & ~rst_i & (lfsr[1:0] != 2'b00), giving about 25% stall cycles.
  - Stall sequences are deterministic and repeatable from reset.
- MEM_STALL_EN undefined: no LFSR is instantiated; gnt_o = req_i & ~rst_i.

Test Plan:
- Write then read, LAT=2:
  - Stimulus: data write addr 0x10, be 4'hF, wdata 0xDEADBEEF accepted at cycle 0; data read addr 0x10 at cycle 1.
  - Response: write rvalid at cycle 2 with rdata 0; read rvalid at cycle 3 with rdata 0xDEADBEEF, err 0.
- Byte enables:
  - Stimulus: word 0x20 holds 0x11223344; write be 4'b0101, wdata 0xAABBCCDD; then read.
  - Response: rdata 0x11BB33DD.
- Out of range, DEPTH=16, BASE_ADDR=0x1000:
  - Stimulus: instr read 0x0FFC; data write 0x1040.
  - Response: both return err = 1, rdata 0, after LAT cycles; a later read of 0x1000 shows memory unchanged.
- Pipelining, LAT=3:
  - Stimulus: 4 consecutive instr reads 0x0, 0x4, 0x8, 0xC with req held high.
  - Response: gnt high for 4 cycles; rvalid high for cycles 3-6 with rdata mem[0..3] in order.
- Collision:
  - Stimulus: word 0x8 holds 0x5; same cycle, instr read 0x8 and data write 0x8 = 0x9.
  - Response: instr rdata 0x5; a following data read returns 0x9.
- Reset mid-flight:
  - Stimulus: data read accepted, then rst_i asserted for 1 cycle before its rvalid.
  - Response: no rvalid appears; gnt is 0 during reset; the next request after reset completes normally.
